// File: rtl/gzip_arbiter.sv
// Round-robin front end that shares one multi-cycle gzip unit among NREQ requesters.
// It sequences the unit (start, wait for done, capture) and a watchdog aborts hung operations.
module gzip_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_rs1,
   input  logic [5*NREQ-1:0]    req_rs2,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_rd,
   output logic                 rsp_err,
   output logic                 gz_start,
   output logic                 gz_reset,
   output logic [31:0]          gz_rs1,
   output logic [4:0]           gz_rs2,
   input  logic [31:0]          gz_rd,
   input  logic                 gz_busy,
   input  logic                 gz_done
);

   localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   ptr_reg, ptr_next;
   logic [IW-1:0]   owner_reg, owner_next;
   logic [7:0]      cnt_reg, cnt_next;
   logic [31:0]     gz_rs1_reg, gz_rs1_next;
   logic [4:0]      gz_rs2_reg, gz_rs2_next;
   logic [31:0]     rsp_rd_reg, rsp_rd_next;
   logic            rsp_err_reg, rsp_err_next;

   logic [31:0]     rs1_arr [NREQ];
   logic [4:0]      rs2_arr [NREQ];
   logic            grant_hit;
   logic [IW-1:0]   grant_idx;
   logic            abort;
   logic            unused_busy;

   // The unit's busy flag is informational; sequencing relies on done and the watchdog only.
   assign unused_busy = gz_busy;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      return IW'(sum);
   endfunction

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign rs1_arr[gi]   = req_rs1[32*gi +: 32];
         assign rs2_arr[gi]   = req_rs2[5*gi +: 5];
         assign req_ready[gi] = (state_reg == IDLE) && grant_hit && (grant_idx == IW'(gi));
         assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == IW'(gi));
      end
   endgenerate

   // Scan from the pointer downward in reverse so the closest requester above ptr wins last.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[wrap_add(ptr_reg, k)]) begin
            grant_hit = 1'b1;
            grant_idx = wrap_add(ptr_reg, k);
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      owner_next   = owner_reg;
      cnt_next     = cnt_reg;
      gz_rs1_next  = gz_rs1_reg;
      gz_rs2_next  = gz_rs2_reg;
      rsp_rd_next  = rsp_rd_reg;
      rsp_err_next = rsp_err_reg;
      abort        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_hit) begin
               gz_rs1_next = rs1_arr[grant_idx];
               gz_rs2_next = rs2_arr[grant_idx];
               owner_next  = grant_idx;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // A done arriving in the final watchdog cycle still counts as success.
            if (gz_done) begin
               rsp_rd_next  = gz_rd;
               rsp_err_next = 1'b0;
               state_next   = RESP;
            end else if (cnt_reg == CNT_LAST) begin
               rsp_rd_next  = '0;
               rsp_err_next = 1'b1;
               abort        = 1'b1;
               state_next   = RESP;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         RESP: begin
            if (rsp_ready[owner_reg]) begin
               ptr_next   = wrap_add(owner_reg, 1);
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         owner_reg   <= '0;
         cnt_reg     <= '0;
         gz_rs1_reg  <= '0;
         gz_rs2_reg  <= '0;
         rsp_rd_reg  <= '0;
         rsp_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         owner_reg   <= owner_next;
         cnt_reg     <= cnt_next;
         gz_rs1_reg  <= gz_rs1_next;
         gz_rs2_reg  <= gz_rs2_next;
         rsp_rd_reg  <= rsp_rd_next;
         rsp_err_reg <= rsp_err_next;
      end
   end

   assign gz_start = (state_reg == ISSUE);
   assign gz_reset = !resetn || abort;
   assign gz_rs1   = gz_rs1_reg;
   assign gz_rs2   = gz_rs2_reg;
   assign rsp_rd   = rsp_rd_reg;
   assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_gzip_arbiter.sv
// Directed bench for gzip_arbiter with a 4-stage behavioural gzip unit model.
module tb_gzip_arbiter;

   logic          clock = 1'b0;
   logic          resetn;
   logic [3:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [127:0]  req_rs1;
   logic [19:0]   req_rs2;
   logic [31:0]   rsp_rd, gz_rs1, gz_rd;
   logic          rsp_err, gz_start, gz_reset, gz_busy, gz_done;
   logic [4:0]    gz_rs2;

   logic [4:0]    pipe = '0;
   logic [31:0]   model_rd = '0;
   logic          hang, inject;
   int            cyc = 0;
   int            hs_cyc, last_rsp_cyc, lat, k;
   int            checks = 0, errors = 0;
   logic [3:0]    acc;

   gzip_arbiter #(.NREQ(4), .TIMEOUT(15)) dut (
      .clock(clock), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rd(rsp_rd), .rsp_err(rsp_err),
      .gz_start(gz_start), .gz_reset(gz_reset),
      .gz_rs1(gz_rs1), .gz_rs2(gz_rs2),
      .gz_rd(gz_rd), .gz_busy(gz_busy), .gz_done(gz_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] stage(input logic [31:0] s, input logic [31:0] ml,
                                         input logic [31:0] mr, input int n);
      return (s & ~(ml | mr)) | ((s << n) & ml) | ((s >> n) & mr);
   endfunction

   function automatic logic [31:0] zip(input logic [31:0] a, input logic [4:0] c);
      logic [31:0] x;
      x = a;
      if (c[4]) x = stage(x, 32'h00ff0000, 32'h0000ff00, 8);
      if (c[3]) x = stage(x, 32'h0f000f00, 32'h00f000f0, 4);
      if (c[2]) x = stage(x, 32'h30303030, 32'h0c0c0c0c, 2);
      if (c[1]) x = stage(x, 32'h44444444, 32'h22222222, 1);
      return x;
   endfunction

   // Unit model: done arrives 5 cycles after the start cycle unless hung.
   always @(posedge clock) begin
      if (gz_reset) pipe <= '0;
      else begin
         pipe <= {pipe[3:0], gz_start};
         if (gz_start) model_rd <= zip(gz_rs1, gz_rs2);
      end
   end
   assign gz_done = (pipe[4] && !hang) || inject;
   assign gz_rd   = model_rd;
   assign gz_busy = |pipe;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; leaves the bench at the negedge of the ISSUE cycle.
   task automatic grant(input int i, input logic [31:0] a, input logic [4:0] c);
      req_rs1[32*i +: 32] = a;
      req_rs2[5*i +: 5]   = c;
      req_valid           = 4'(1 << i);
      #1;
      check("grant", 32'(req_ready), 32'(1 << i));
      hs_cyc = cyc;
      @(negedge clock);
      req_valid = '0;
      check("start", 32'(gz_start), 32'd1);
      check("gz_rs1", gz_rs1, a);
      check("gz_rs2", 32'(gz_rs2), 32'(c));
   endtask

   task automatic wait_rsp(output int l);
      for (int n = 0; n < 40; n++) begin
         if (rsp_valid != 0) break;
         @(negedge clock);
      end
      l = cyc - hs_cyc;
   endtask

   task automatic finish_rsp(input int i, input logic [31:0] rd, input logic err, input int elat);
      int l;
      wait_rsp(l);
      check("latency", 32'(l), 32'(elat));
      check("rsp_valid", 32'(rsp_valid), 32'(1 << i));
      check("rsp_rd", rsp_rd, rd);
      check("rsp_err", 32'(rsp_err), 32'(err));
      $display("op req=%0d rd=%h err=%0d lat=%0d", i, rsp_rd, rsp_err, l);
      rsp_ready = 4'(1 << i);
      @(negedge clock);
      rsp_ready = '0;
      check("rsp_drop", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; req_valid = '0; rsp_ready = '0; req_rs1 = '0; req_rs2 = '0;
      hang = 1'b0; inject = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_gz_start", 32'(gz_start), 32'd0);
      check("rst_gz_reset", 32'(gz_reset), 32'd1);
      check("rst_rsp_rd", rsp_rd, 32'd0);
      resetn = 1'b1;
      @(negedge clock);
      check("idle_gz_reset", 32'(gz_reset), 32'd0);

      // bypass and byte zip
      grant(0, 32'h12345678, 5'h00);
      finish_rsp(0, 32'h12345678, 1'b0, 7);
      grant(2, 32'h12345678, 5'h10);
      finish_rsp(2, 32'h12563478, 1'b0, 7);

      // backpressure on requester 1, other rsp_ready bits high and must be ignored
      grant(1, 32'hCAFEBABE, 5'h00);
      wait_rsp(lat);
      check("bp_latency", 32'(lat), 32'd7);
      req_rs1[31:0] = 32'h0F0F0F0F;
      req_valid = 4'b0001;
      rsp_ready = 4'b1101;
      acc = '0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         check("bp_valid", 32'(rsp_valid), 32'h2);
         check("bp_rd", rsp_rd, 32'hCAFEBABE);
         acc = acc | req_ready;
      end
      check("bp_no_grant", 32'(acc), 32'd0);
      rsp_ready = 4'b0010;
      @(negedge clock);
      rsp_ready = '0;
      grant(0, 32'h0F0F0F0F, 5'h00);
      finish_rsp(0, 32'h0F0F0F0F, 1'b0, 7);

      // timeout on requester 3
      hang = 1'b1;
      grant(3, 32'hDEADBEEF, 5'h00);
      for (k = 0; k < 30; k++) begin
         if (gz_reset) break;
         @(negedge clock);
      end
      check("abort_cycle", 32'(cyc - hs_cyc), 32'd16);
      @(negedge clock);
      check("abort_pulse_end", 32'(gz_reset), 32'd0);
      finish_rsp(3, 32'h0, 1'b1, 17);

      // done coincides with the last watchdog cycle: done wins
      grant(1, 32'h12345678, 5'h10);
      repeat (15) @(negedge clock);
      inject = 1'b1;
      #1;
      check("coincide_no_abort", 32'(gz_reset), 32'd0);
      @(negedge clock);
      inject = 1'b0;
      finish_rsp(1, 32'h12563478, 1'b0, 17);
      hang = 1'b0;

      // asynchronous reset during WAIT
      grant(2, 32'h55AA55AA, 5'h00);
      repeat (3) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_gz_start", 32'(gz_start), 32'd0);
      check("mid_gz_reset", 32'(gz_reset), 32'd1);
      check("mid_gz_rs1", gz_rs1, 32'd0);
      check("mid_rsp_rd", rsp_rd, 32'd0);
      check("mid_rsp_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      acc = '0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         acc = acc | rsp_valid;
      end
      check("mid_no_rsp", 32'(acc), 32'd0);

      // round robin with all requesters active
      for (int i = 0; i < 4; i++) begin
         req_rs1[32*i +: 32] = 32'h10000000 * (i + 1) + i;
         req_rs2[5*i +: 5]   = 5'h00;
      end
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (k = 0; k < 20; k++) begin
            #1;
            if (req_ready != 0) break;
            @(negedge clock);
         end
         check("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
         if (g > 0) check("rr_gap", 32'(cyc - last_rsp_cyc), 32'd1);
         hs_cyc = cyc;
         @(negedge clock);
         wait_rsp(lat);
         check("rr_latency", 32'(lat), 32'd7);
         check("rr_rd", rsp_rd, 32'h10000000 * ((g % 4) + 1) + (g % 4));
         $display("op req=%0d rd=%h err=%0d lat=%0d", g % 4, rsp_rd, rsp_err, lat);
         last_rsp_cyc = cyc;
         if (g == 4) req_valid = '0;
         @(negedge clock);
      end
      rsp_ready = '0;

      // stray done in IDLE
      inject = 1'b1;
      @(negedge clock);
      inject = 1'b0;
      acc = '0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         acc = acc | rsp_valid | req_ready | {3'b0, gz_start};
      end
      check("stray_done", 32'(acc), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
